alu_mul_sequencer: RTL and testbench

Multi-cycle unsigned 32×32→64 multiply controller that borrows the shared 32-bit ALU. It arbitrates the ALU between the main datapath and its own shift-add sequence, and drives the ALU operand and select lines itself while a multiply runs. The result lands in internal HI/LO registers, and the datapath is stalled for the duration. It sits beside the ALU in the mips32 datapath and serves MULTU.

---
 rtl/alu_mul_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Unsigned 32x32->64 shift-add multiply sequencer that borrows the shared ALU.
// Latency: 64 busy cycles after the accepted start, then a 1-cycle done pulse.
// No backpressure: start is honoured only in IDLE, otherwise dropped; busy stalls the datapath.
module alu_mul_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  input  logic [31:0] dp_a,
  input  logic [31:0] dp_b,
  input  logic [2:0]  dp_sel,
  input  logic [31:0] alu_out,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic [31:0] dp_result,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  localparam logic [2:0] SEL_ADD  = 3'b010;
  localparam logic [2:0] SEL_SHR  = 3'b101;
  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  state_t      state, state_nxt;
  logic [31:0] mc_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        carry;
  logic [4:0]  cnt;

  // State register; reset always lands in IDLE.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, ALU mux ownership and status decodes. While reset is high the
  // mux is forced back to passthrough so the datapath regains the ALU at once.
  always_comb begin
    state_nxt = state;
    alu_a     = dp_a;
    alu_b     = dp_b;
    alu_sel   = dp_sel;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ADD;
      end
      ADD: begin
        busy      = 1'b1;
        state_nxt = SHIFT;
        if (!reset) begin
          alu_a   = hi_r;
          alu_b   = lo_r[0] ? mc_r : 32'd0;
          alu_sel = SEL_ADD;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        state_nxt = (cnt == CNT_LAST) ? DONE : ADD;
        if (!reset) begin
          alu_a   = hi_r;
          alu_b   = 32'd1;
          alu_sel = SEL_SHR;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply datapath: capture operands, accumulate into hi with a locally
  // derived carry (the ALU does not export one), then shift {carry,hi,lo} right.
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_r  <= 32'd0;
      hi_r  <= 32'd0;
      lo_r  <= 32'd0;
      carry <= 1'b0;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mc_r  <= mcand;
            hi_r  <= 32'd0;
            lo_r  <= mplier;
            carry <= 1'b0;
            cnt   <= 5'd0;
          end
        end
        ADD: begin
          hi_r  <= alu_out;
          carry <= (alu_out < hi_r);
        end
        SHIFT: begin
          hi_r  <= {carry, alu_out[30:0]};
          lo_r  <= {hi_r[0], lo_r[31:1]};
          carry <= 1'b0;
          cnt   <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign dp_result = alu_out;
  assign hi        = hi_r;
  assign lo        = lo_r;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] mcand, mplier;
  logic [31:0] dp_a, dp_b;
  logic [2:0]  dp_sel;
  logic [31:0] alu_out;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] dp_result;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .alu_out(alu_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .dp_result(dp_result),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Shared ALU model
  always_comb begin
    case (alu_sel)
      3'b010:  alu_out = alu_a + alu_b;
      3'b101:  alu_out = alu_a >> alu_b[4:0];
      3'b000:  alu_out = alu_a & alu_b;
      3'b001:  alu_out = alu_a | alu_b;
      default: alu_out = alu_a - alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One multiply; glitch_at >= 0 re-pulses start (with other operands) that many cycles in.
  task automatic run_mul(input string tag, input logic [31:0] mc, input logic [31:0] mp,
                         input logic [63:0] exp, input int glitch_at);
    int n;
    int busy_n;
    bit sel_ok;
    start = 1'b1; mcand = mc; mplier = mp;
    tick();
    start = 1'b0; mcand = 32'hA5A5_A5A5; mplier = 32'h5A5A_5A5A;
    n = 0; busy_n = 0; sel_ok = 1'b1;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      if (alu_sel !== ((n % 2 == 0) ? 3'b010 : 3'b101)) sel_ok = 1'b0;
      dp_a = $urandom; dp_b = $urandom; dp_sel = 3'b000;
      start = (n == glitch_at);
      tick();
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'd64);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd64);
    chk({tag, "_alu_owned"}, 64'(sel_ok), 64'd1);
    chk({tag, "_product"}, {hi, lo}, exp);
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    dp_a = 32'd12; dp_b = 32'd10; dp_sel = 3'b010;
    #1;
    chk({tag, "_pass_in_done"}, 64'(dp_result), 64'd22);
    start = 1'b1;                       // ignored while in DONE
    tick();
    start = 1'b0;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    tick();
    chk({tag, "_no_start_from_done"}, 64'(busy), 64'd0);
    chk({tag, "_hold"}, {hi, lo}, exp);
  endtask

  initial begin
    int n;
    bit done_seen;
    reset = 1'b1; start = 1'b0; mcand = 32'd0; mplier = 32'd0;
    dp_a = 32'd0; dp_b = 32'd0; dp_sel = 3'b000;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    // Combinational passthrough while idle
    dp_a = 32'd7; dp_b = 32'd9; dp_sel = 3'b010;
    #1;
    chk("pass_a", 64'(alu_a), 64'd7);
    chk("pass_b", 64'(alu_b), 64'd9);
    chk("pass_sel", 64'(alu_sel), 64'd2);
    chk("pass_result", 64'(dp_result), 64'd16);
    tick();

    run_mul("m3x5",    32'd3,         32'd5,         64'h0000_0000_0000_000F, -1);
    run_mul("max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
    run_mul("msb_x2",  32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000, -1);
    run_mul("mc0",     32'd0,         32'h1234_5678, 64'd0, -1);
    run_mul("mp0",     32'hDEAD_BEEF, 32'd0,         64'd0, -1);
    run_mul("ffx2",    32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, -1);
    run_mul("glitch",  32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 10);

    // Back-to-back: accept start immediately after returning to IDLE
    run_mul("b2b",     32'd3,         32'd5,         64'h0000_0000_0000_000F, -1);

    // Reset mid-multiply aborts cleanly
    start = 1'b1; mcand = 32'd7; mplier = 32'd6;
    tick();
    start = 1'b0;
    repeat (20) tick();
    dp_a = 32'h0000_00F0; dp_b = 32'h0000_000F; dp_sel = 3'b001;
    reset = 1'b1;
    #1;
    chk("reset_mux_pass", 64'(alu_sel), 64'd1);
    chk("reset_mux_result", 64'(dp_result), 64'h0FF);
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    done_seen = 1'b0;
    for (n = 0; n < 70; n++) begin
      if (done || busy) done_seen = 1'b1;
      tick();
    end
    chk("abort_quiet", 64'(done_seen), 64'd0);
    run_mul("fresh",   32'd7,         32'd6,         64'd42, -1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
